clk_divider: RTL and testbench

Integer clock divider with a companion input synchroniser. It derives a divided clock-enable-style square wave `clk_out` from `clk_in`, and passes a single-bit input `a` through a two-flop stage to `b`. Both functions run in the `clk_in` domain. The block sits at the clock-generation edge of the design, feeding slower downstream logic.

---
 rtl/clk_divider_pkg.sv | 22 ++
 rtl/clk_divider_if.sv | 23 ++
 rtl/clk_divider_sync_ff.sv | 39 +++
 rtl/clk_divider.sv | 67 ++++++
 tb/tb_clk_divider.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/clk_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_pkg
//  Description : Helper functions shared by the clock divider slice.
//                calc_high() gives the number of high cycles per period
//                (ceil(DIV/2)); cnt_width() gives the divider counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_divider_pkg;

    // High portion of the period; odd ratios bias toward high.
    function automatic int calc_high(input int div);
        return div - (div / 2);
    endfunction

    // Counter width, never below one bit.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage : clk_divider_pkg
`default_nettype wire

// File: rtl/clk_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_if
//  Description : Signal bundle for the clock divider.
//                a       - single-bit input to be synchronised
//                b       - a delayed by the sync chain
//                clk_out - divided square wave
//                master: drives a, observes b / clk_out
//                slave : the divider itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_divider_if;
    import clk_divider_pkg::*;

    logic a;
    logic b;
    logic clk_out;

    modport master (output a, input  b, input  clk_out);
    modport slave  (input  a, output b, output clk_out);

endinterface : clk_divider_if
`default_nettype wire

// File: rtl/clk_divider_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : N-stage shift register, reset to 0, used to carry a
//                single bit into the clk domain.
//                clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                d     - input bit
//                q     - d delayed by STAGES clock edges
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff
    import clk_divider_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= '0;
        end else begin
            r_s[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_s[i] <= r_s[i-1];
            end
        end
    end

    assign q = r_s[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/clk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider
//  Description : Integer clock divider plus input synchroniser, all in the
//                clk_in domain.
//                clk_in      - sole clock, rising edge
//                rst_n       - synchronous active-low reset
//                bus.a       - input bit, synchronised to bus.b
//                bus.b       - a delayed by SYNC_STAGES edges (registered)
//                bus.clk_out - DIV-cycle square wave, high ceil(DIV/2)
//                              cycles per period (registered fabric signal)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int DIV         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_in,
    input  logic          rst_n,
    clk_divider_if.slave  bus
);

    localparam int                 c_CNT_W   = cnt_width(DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HIGH    = c_CNT_W'(calc_high(DIV));

    generate
        if (DIV < 2) begin : g_bad_div
            $error("clk_divider: DIV must be >= 2");
        end
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("clk_divider: SYNC_STAGES must be >= 1");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_clk_out;
    logic               w_b;

    // clk_out reflects the pre-update count, so the first edge after
    // reset (cnt = 0) drives it high.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else begin
            r_clk_out <= (r_cnt < c_HIGH);
            r_cnt     <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk_in),
        .rst_n  (rst_n),
        .d      (bus.a),
        .q      (w_b)
    );

    assign bus.clk_out = r_clk_out;
    assign bus.b       = w_b;

endmodule : clk_divider
`default_nettype wire

// File: tb/tb_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_divider
//  Description : Scoreboard bench for clk_divider with DIV = 2, 3 and 5
//                instances sharing clock, reset and input a.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_divider;

    typedef struct {
        logic c2;
        logic c3;
        logic c5;
        logic b;
    } exp_t;

    logic clk     = 1'b0;
    logic clk_run = 1'b1;
    logic rst_n   = 1'b0;
    logic a       = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t q_exp[$];
    exp_t last;

    // Hand-written per-period waveforms, first post-reset edge at the MSB.
    logic [1:0] pat2 = 2'b10;
    logic [2:0] pat3 = 3'b110;
    logic [4:0] pat5 = 5'b11100;
    int   ph2, ph3, ph5;
    logic a_d1;

    initial forever begin
        #10;
        if (clk_run) clk = ~clk;
    end

    clk_divider_if bus2 ();
    clk_divider_if bus3 ();
    clk_divider_if bus5 ();

    assign bus2.a = a;
    assign bus3.a = a;
    assign bus5.a = a;

    clk_divider #(.DIV(2), .SYNC_STAGES(2)) u_dut2 (.clk_in(clk), .rst_n(rst_n), .bus(bus2));
    clk_divider #(.DIV(3), .SYNC_STAGES(2)) u_dut3 (.clk_in(clk), .rst_n(rst_n), .bus(bus3));
    clk_divider #(.DIV(5), .SYNC_STAGES(2)) u_dut5 (.clk_in(clk), .rst_n(rst_n), .bus(bus5));

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, wait for the edge, push the expected post-edge outputs.
    task automatic step(input logic r, input logic av);
        rst_n = r;
        a     = av;
        @(posedge clk);
        if (!r) begin
            ph2  = 0;
            ph3  = 0;
            ph5  = 0;
            a_d1 = 1'b0;
            last = '{c2: 1'b0, c3: 1'b0, c5: 1'b0, b: 1'b0};
        end else begin
            last.c2 = pat2[1 - ph2];
            last.c3 = pat3[2 - ph3];
            last.c5 = pat5[4 - ph5];
            ph2     = (ph2 + 1) % 2;
            ph3     = (ph3 + 1) % 3;
            ph5     = (ph5 + 1) % 5;
            last.b  = a_d1;
            a_d1    = av;
        end
        q_exp.push_back(last);
        #2;
    endtask

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #5;
        if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=edge required=no_edge t=%0t", $time);
        end else begin
            e = q_exp.pop_front();
            chk("clk_out_div2", bus2.clk_out, e.c2);
            chk("clk_out_div3", bus3.clk_out, e.c3);
            chk("clk_out_div5", bus5.clk_out, e.c5);
            chk("b_sync",       bus2.b,       e.b);
            chk("b_sync_div3",  bus3.b,       e.b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ph2  = 0;
        ph3  = 0;
        ph5  = 0;
        a_d1 = 1'b0;
        last = '{c2: 1'b0, c3: 1'b0, c5: 1'b0, b: 1'b0};

        // Reset held 3 edges with a = 1.
        repeat (3) step(1'b0, 1'b1);

        // Free run, a low for 10 edges, then raise a, then lower it.
        repeat (10) step(1'b1, 1'b0);
        repeat (6)  step(1'b1, 1'b1);
        repeat (5)  step(1'b1, 1'b0);

        // Bring b high and wait until DIV=2 output is high too.
        repeat (3) step(1'b1, 1'b1);
        for (int i = 0; i < 8 && !(last.c2 && last.b); i++) step(1'b1, 1'b1);
        checks++;
        if (!(last.c2 && last.b)) begin
            errors++;
            $display("FAIL midreset_precond actual=%b%b required=11", last.c2, last.b);
        end

        // Mid-operation reset, then clean restart.
        step(1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b1);
        repeat (4)  step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Clock stop: hold clk low for 1000 ns while toggling a.
        @(negedge clk);
        clk_run = 1'b0;
        repeat (50) begin
            #20;
            a = ~a;
            if (a) begin
                chk("stop_b_midway", bus2.b, last.b);
            end
        end
        chk("stop_clk_out_div2", bus2.clk_out, last.c2);
        chk("stop_clk_out_div3", bus3.clk_out, last.c3);
        chk("stop_clk_out_div5", bus5.clk_out, last.c5);
        chk("stop_b",            bus2.b,       last.b);
        #1;
        clk_run = 1'b1;

        // Resume.
        repeat (4) step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1);

        #10;
        clk_run = 1'b0;
        #20;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q_exp.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_divider
`default_nettype wire
